hamming_secded_decoder_pipe: RTL and testbench

Parametrised extended-Hamming (SECDED) decoder with a 2-stage valid/ready pipeline. It corrects single-bit errors and detects double-bit errors on a CODE_W-bit codeword. It also reports the syndrome and a per-word error class, and keeps saturating corrected/uncorrectable event counters. It sits on the receive side of the link, after the deserialiser and ahead of the data consumer.

---
 rtl/hamming_pkg.sv | 32 +++
 rtl/hamming_syndrome_calc.sv | 22 ++
 rtl/hamming_secded_decoder_pipe.sv | 152 +++++++++++++++
 tb/tb_hamming_secded_decoder_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and helpers for the SECDED decoder.
// Provides parity-width sizing, a power-of-two test and the per-word error class.
package hamming_pkg;

  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_DOUBLE
  } err_class_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int unsigned calc_par_w(input int unsigned data_w);
    int unsigned r;
    logic        found;
    r     = 1;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_DATA_W; k++) begin
      if (!found && ((64'd1 << k) >= 64'(data_w + k + 1))) begin
        r     = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational Hamming syndrome and overall parity of a codeword.
//   code     : codeword, bit 0 = overall parity, bit k = Hamming position k
//   syndrome : XOR of the indices of all set bits at positions 1..CODE_W-1
//   parity   : XOR of every bit (0 for an intact even-parity word)
module hamming_syndrome_calc #(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned PAR_W  = 3
) (
  input  logic [CODE_W-1:0] code,
  output logic [PAR_W-1:0]  syndrome,
  output logic              parity
);

  always_comb begin
    syndrome = '0;
    for (int unsigned k = 1; k < CODE_W; k++) begin
      if (code[k]) syndrome = syndrome ^ PAR_W'(k);
    end
    parity = ^code;
  end

endmodule

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage valid/ready extended-Hamming (SECDED) decoder with saturating event counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : codeword handshake, in_code = received codeword
//   out_valid/out_ready   : decoded word handshake
//   out_data              : corrected payload
//   out_syndrome          : raw Hamming syndrome
//   out_err_single/double : corrected / uncorrectable flags
//   cnt_clr               : synchronous clear of corr_cnt and uncorr_cnt
module hamming_secded_decoder_pipe
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W  = calc_par_w(DATA_W),
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Hamming position holding data bit j.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned k = 1; k < CODE_W; k++) begin
      if (!is_pow2(int'(k))) begin
        if (cnt == j) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;

  logic [PAR_W-1:0]  syn_c;
  logic              par_c;
  logic [DATA_W-1:0] raw_data_c;
  logic [DATA_W-1:0] corr_data_c;
  err_class_e        cls_c;
  logic              do_flip_c;
  logic              s2_ready;
  logic              in_fire;
  logic              out_fire;

  // Purely combinational ready chain so a full pipe still streams.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  hamming_syndrome_calc #(
    .CODE_W (CODE_W),
    .PAR_W  (PAR_W)
  ) u_syn (
    .code     (in_code),
    .syndrome (syn_c),
    .parity   (par_c)
  );

  // Check bits are fully consumed by the syndrome, so only payload positions travel to S2.
  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    localparam int unsigned POS = data_pos(j);
    assign raw_data_c[j]  = in_code[POS];
    assign corr_data_c[j] = s1_data[j] ^ (do_flip_c && (s1_syn == PAR_W'(POS)));
  end

  // Error classification; syndromes beyond the shortened code are uncorrectable.
  always_comb begin
    cls_c     = ERR_NONE;
    do_flip_c = 1'b0;
    if (!s1_par) begin
      cls_c = (s1_syn == '0) ? ERR_NONE : ERR_DOUBLE;
    end else if (s1_syn == '0) begin
      cls_c = ERR_SINGLE;
    end else if (32'(s1_syn) < CODE_W) begin
      cls_c     = ERR_SINGLE;
      do_flip_c = 1'b1;
    end else begin
      cls_c = ERR_DOUBLE;
    end
  end

  // S1 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // S1 payload, syndrome and parity.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_data <= raw_data_c;
      s1_syn  <= syn_c;
      s1_par  <= par_c;
    end
  end

  // S2 drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_syndrome   <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data       <= corr_data_c;
        out_syndrome   <= s1_syn;
        out_err_single <= (cls_c == ERR_SINGLE);
        out_err_double <= (cls_c == ERR_DOUBLE);
      end
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (out_err_single && (corr_cnt != '1))   corr_cnt   <= corr_cnt + CNT_W'(1);
      if (out_err_double && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Directed self-checking bench for hamming_secded_decoder_pipe (DATA_W=4, CNT_W=2).
module tb_hamming_secded_decoder_pipe;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PAR_W  = 3;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned NSTRM  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CODE_W-1:0] in_code = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_err_single;
  logic              out_err_double;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  logic [CODE_W-1:0] enc_raw = '0;
  logic [PAR_W-1:0]  enc_syn;
  logic              enc_par;

  int total = 0;
  int bad   = 0;

  logic [CODE_W-1:0] enc_tab [16];

  always #5 clk = ~clk;

  hamming_secded_decoder_pipe #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_code        (in_code),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_syndrome   (out_syndrome),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .cnt_clr        (cnt_clr),
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt)
  );

  // Encoder model built on the syndrome block.
  hamming_syndrome_calc #(
    .CODE_W (CODE_W),
    .PAR_W  (PAR_W)
  ) u_enc (
    .code     (enc_raw),
    .syndrome (enc_syn),
    .parity   (enc_par)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data bits at positions 3,5,6,7; check bits at 1,2,4; overall parity at 0.
  task automatic encode(input logic [3:0] d, output logic [CODE_W-1:0] c);
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    enc_raw = c;
    #1;
    c[1] = enc_syn[0];
    c[2] = enc_syn[1];
    c[4] = enc_syn[2];
    enc_raw = c;
    #1;
    c[0] = enc_par;
  endtask

  task automatic send_check(input string tag, input logic [7:0] code, input logic [3:0] ed,
                            input logic [2:0] es, input logic e1, input logic e2,
                            input logic [1:0] ecorr, input logic [1:0] eunc, input logic clr);
    @(negedge clk);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = '0;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_syn"}, 32'(out_syndrome), 32'(es));
    chk({tag, "_single"}, 32'(out_err_single), 32'(e1));
    chk({tag, "_double"}, 32'(out_err_double), 32'(e2));
    cnt_clr = clr;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk({tag, "_corr"}, 32'(corr_cnt), 32'(ecorr));
    chk({tag, "_uncorr"}, 32'(uncorr_cnt), 32'(eunc));
    chk({tag, "_pop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [CODE_W-1:0] c;
    logic [CODE_W-1:0] scode [NSTRM];
    logic [3:0]        sdat  [NSTRM];
    logic [2:0]        ssyn  [NSTRM];
    logic              ssgl  [NSTRM];
    logic              sdbl  [NSTRM];
    int                sent, rcvd, cyc;
    logic              stalled_prev, saw_block;
    logic [3:0]        snap_d;
    logic [2:0]        snap_s;
    logic              snap_1, snap_2, fire_in;

    for (int i = 0; i < 16; i++) begin
      encode(4'(i), c);
      enc_tab[i] = c;
    end
    chk("enc_B", 32'(enc_tab[11]), 32'h0000_00AA);

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_syn", 32'(out_syndrome), 32'd0);
    chk("rst_flags", 32'({out_err_single, out_err_double}), 32'd0);
    chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed vectors.
    send_check("clean", 8'hAA, 4'hB, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    send_check("pos5",  8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
    send_check("bit0",  8'hAB, 4'hB, 3'd0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0);
    send_check("dbl",   8'hAC, 4'hB, 3'd3, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0);

    // Back-to-back stream with a 4-cycle consumer stall.
    for (int i = 0; i < NSTRM; i++) begin
      sdat[i] = 4'((i * 5 + 3) & 15);
      scode[i] = enc_tab[sdat[i]];
      ssyn[i] = 3'd0; ssgl[i] = 1'b0; sdbl[i] = 1'b0;
      if (i == 2) begin scode[i] ^= 8'h40; ssyn[i] = 3'd6; ssgl[i] = 1'b1; end
      if (i == 5) begin scode[i] ^= 8'h01; ssyn[i] = 3'd0; ssgl[i] = 1'b1; end
      if (i == 7) begin scode[i] ^= 8'h12; ssyn[i] = 3'd5; sdbl[i] = 1'b1; end
    end
    sent = 0; rcvd = 0; cyc = 0;
    stalled_prev = 1'b0; saw_block = 1'b0;
    snap_d = '0; snap_s = '0; snap_1 = 1'b0; snap_2 = 1'b0;
    while (rcvd < int'(NSTRM) && cyc < 100) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < int'(NSTRM));
      in_code   = (sent < int'(NSTRM)) ? scode[sent] : '0;
      #1;
      if (stalled_prev) begin
        chk("stall_data", 32'(out_data), 32'(snap_d));
        chk("stall_syn", 32'(out_syndrome), 32'(snap_s));
        chk("stall_flags", 32'({out_err_single, out_err_double}), 32'({snap_1, snap_2}));
        chk("stall_valid", 32'(out_valid), 32'd1);
      end
      if (!in_ready) saw_block = 1'b1;
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("strm_data", 32'(out_data), 32'(sdat[rcvd]));
        chk("strm_syn", 32'(out_syndrome), 32'(ssyn[rcvd]));
        chk("strm_single", 32'(out_err_single), 32'(ssgl[rcvd]));
        chk("strm_double", 32'(out_err_double), 32'(sdbl[rcvd]));
        rcvd++;
      end
      stalled_prev = out_valid && !out_ready;
      snap_d = out_data; snap_s = out_syndrome;
      snap_1 = out_err_single; snap_2 = out_err_double;
      if (fire_in) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    in_code  = '0;
    chk("strm_count", 32'(rcvd), 32'(NSTRM));
    chk("strm_block", 32'(saw_block), 32'd1);
    repeat (3) @(negedge clk);
    chk("strm_drain", 32'(out_valid), 32'd0);

    // Counter saturation and clear priority.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_corr", 32'(corr_cnt), 32'd0);
    chk("clr_uncorr", 32'(uncorr_cnt), 32'd0);
    send_check("sat1", 8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
    send_check("sat2", 8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0);
    send_check("sat3", 8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
    send_check("sat4", 8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
    send_check("sat5", 8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
    send_check("clrwin", 8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 8'h8A;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_corr", 32'(corr_cnt != '0), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_flags", 32'({out_err_single, out_err_double}), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    in_code  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
